// File: rtl/sram_arbiter_pkg.sv
// ============================================================================
//  Module   : sram_arbiter_pkg
//  Purpose  : Shared state encodings, timing default and math helper for the
//             two-port SRAM arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam int c_t_access_ns = 70;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Round-robin arbiter granting two requesters timed access to an
//             asynchronous SRAM with registered strobes.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int CLK_FREQ    = 50,
    parameter int T_ACCESS_NS = c_t_access_ns,
    parameter int ADDR_BITS   = 20,
    parameter int DATA_BITS   = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_req,
    input  logic                 m0_we,
    input  logic [ADDR_BITS-1:0] m0_addr,
    input  logic [DATA_BITS-1:0] m0_din,
    output logic [DATA_BITS-1:0] m0_dout,
    output logic                 m0_ack,
    input  logic                 m1_req,
    input  logic                 m1_we,
    input  logic [ADDR_BITS-1:0] m1_addr,
    input  logic [DATA_BITS-1:0] m1_din,
    output logic [DATA_BITS-1:0] m1_dout,
    output logic                 m1_ack,
    output logic                 sram_ce_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [DATA_BITS-1:0] sram_dout,
    input  logic [DATA_BITS-1:0] sram_din,
    output logic [1:0]           state
);

    localparam int c_wait_raw = ceil_div(T_ACCESS_NS * CLK_FREQ, 1000);
    localparam int c_wait     = (c_wait_raw < 1) ? 1 : c_wait_raw;
    localparam int c_cnt_w    = $clog2(c_wait + 1);
    localparam logic [c_cnt_w-1:0] c_rd_last = c_cnt_w'(c_wait - 1);
    // Write count 0 is the address-setup cycle, so its strobe window ends one later.
    localparam logic [c_cnt_w-1:0] c_wr_last = c_cnt_w'(c_wait);

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_port;
    logic                   r_last;
    logic                   r_ce_n;
    logic                   r_oe_n;
    logic                   r_we_n;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [DATA_BITS-1:0]   r_sdout;
    logic [DATA_BITS-1:0]   r_dout0;
    logic [DATA_BITS-1:0]   r_dout1;
    logic                   r_ack0;
    logic                   r_ack1;

    logic                   w_any;
    logic                   w_pick;
    logic                   w_we;
    logic [ADDR_BITS-1:0]   w_addr;
    logic [DATA_BITS-1:0]   w_din;

    assign w_any  = m0_req | m1_req;
    assign w_pick = (m0_req & m1_req) ? ~r_last : m1_req;
    assign w_we   = w_pick ? m1_we   : m0_we;
    assign w_addr = w_pick ? m1_addr : m0_addr;
    assign w_din  = w_pick ? m1_din  : m0_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_port  <= 1'b0;
            r_last  <= 1'b1;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_addr  <= '0;
            r_sdout <= '0;
            r_dout0 <= '0;
            r_dout1 <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_ce_n <= 1'b1;
                    r_oe_n <= 1'b1;
                    r_we_n <= 1'b1;
                    if (w_any) begin
                        r_port  <= w_pick;
                        r_last  <= w_pick;
                        r_addr  <= w_addr;
                        r_sdout <= w_din;
                        r_cnt   <= '0;
                        r_ce_n  <= 1'b0;
                        if (w_we) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_READ;
                            r_oe_n  <= 1'b0;
                        end
                    end
                end
                ST_READ: begin
                    if (r_cnt == c_rd_last) begin
                        if (r_port) r_dout1 <= sram_din;
                        else        r_dout0 <= sram_din;
                        r_ack0  <= ~r_port;
                        r_ack1  <= r_port;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_state <= ST_RECOVER;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                ST_WRITE: begin
                    if (r_cnt == c_wr_last) begin
                        r_ack0  <= ~r_port;
                        r_ack1  <= r_port;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_state <= ST_RECOVER;
                    end else begin
                        r_we_n <= 1'b0;
                        r_cnt  <= r_cnt + c_cnt_w'(1);
                    end
                end
                ST_RECOVER: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    assign m0_dout   = r_dout0;
    assign m1_dout   = r_dout1;
    assign m0_ack    = r_ack0;
    assign m1_ack    = r_ack1;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_addr = r_addr;
    assign sram_dout = r_sdout;
    assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
//  Module   : tb_sram_arbiter
//  Purpose  : Self-checking bench for sram_arbiter with an SRAM pad model and
//             a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_arbiter;

    localparam int CLK_FREQ    = 50;
    localparam int T_ACCESS_NS = 70;
    localparam int AW          = 20;
    localparam int DW          = 48;
    localparam int WAIT_RAW    = (T_ACCESS_NS * CLK_FREQ + 999) / 1000;
    localparam int WAIT        = (WAIT_RAW < 1) ? 1 : WAIT_RAW;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_ack;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_din, m0_dout;
    logic          m1_req, m1_we, m1_ack;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_din, m1_dout;
    logic          sram_ce_n, sram_oe_n, sram_we_n;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_dout;
    logic [DW-1:0] sram_din = '0;
    logic [1:0]    state;

    sram_arbiter #(
        .CLK_FREQ(CLK_FREQ), .T_ACCESS_NS(T_ACCESS_NS), .ADDR_BITS(AW), .DATA_BITS(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_dout(m0_dout), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_dout(m1_dout), .m1_ack(m1_ack),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .state(state)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pad memory (the SRAM chip) and the reference model's view of memory.
    logic [DW-1:0] pad_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_mem [logic [AW-1:0]];
    logic [DW-1:0] exp_dout [2];
    bit            model_last;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0], 16'hC3A5};
    endfunction

    function automatic logic [DW-1:0] pad_get(input logic [AW-1:0] a);
        if (pad_mem.exists(a)) return pad_mem[a];
        return init_val(a);
    endfunction

    function automatic logic [DW-1:0] exp_get(input logic [AW-1:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return init_val(a);
    endfunction

    function automatic int lat(input bit we);
        return we ? WAIT + 1 : WAIT;
    endfunction

    int            oe_cnt = 0, we_cnt = 0, setup_cnt = 0;
    logic [AW-1:0] prev_addr = '0;
    logic          prev_we_n = 1'b1;

    always @(negedge clk) begin
        if (sram_ce_n === 1'b0 && sram_we_n === 1'b0) pad_mem[sram_addr] = sram_dout;
        sram_din = (sram_ce_n === 1'b0 && sram_oe_n === 1'b0) ? pad_get(sram_addr) : 48'hDEAD_BEEF_0BAD;
        if (sram_oe_n === 1'b0) oe_cnt++;
        if (sram_we_n === 1'b0) begin
            we_cnt++;
            check_eq("oe_we_exclusive", sram_oe_n, 1);
            if (prev_we_n === 1'b0) check_eq("waddr_stable", sram_addr, prev_addr);
        end
        if (sram_ce_n === 1'b0 && sram_we_n === 1'b1 && sram_oe_n === 1'b1) setup_cnt++;
        prev_addr = sram_addr;
        prev_we_n = sram_we_n;
    end

    task automatic model_apply(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (we) exp_mem[a] = d;
        else    exp_dout[p] = exp_get(a);
        model_last = p[0];
    endtask

    task automatic model_reset();
        model_last  = 1'b1;
        exp_dout[0] = '0;
        exp_dout[1] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_state", state, 0);
        check_eq("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check_eq("rst_addr", sram_addr, 0);
        check_eq("rst_sdout", sram_dout, 0);
        check_eq("rst_douts", {m0_dout, m1_dout}, 0);
        check_eq("rst_acks", {m0_ack, m1_ack}, 0);
        rst = 1'b0;
        model_reset();
    endtask

    // Issue one or two simultaneous requests and follow them to completion.
    task automatic run_pair(input bit r0, input bit r1, input bit w0, input bit w1,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        int            k, first, second, n_rd, n_wr, o;
        int            exp_t [2];
        int            got_t [2];
        bit            act [2];
        bit            done [2];
        bit            wv [2];
        logic [AW-1:0] av [2];
        logic [DW-1:0] dv [2];
        logic [DW-1:0] snap [2][2];
        logic          ackb;
        act[0] = r0; act[1] = r1; wv[0] = w0; wv[1] = w1;
        av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1;
        done[0] = 0; done[1] = 0; got_t[0] = -1; got_t[1] = -1; exp_t[0] = -1; exp_t[1] = -1;
        first  = (r0 && r1) ? (model_last ? 0 : 1) : (r1 ? 1 : 0);
        second = 1 - first;
        k = cyc;
        n_rd = 0; n_wr = 0;
        exp_t[first] = k + 1 + lat(wv[first]);
        model_apply(first, wv[first], av[first], dv[first]);
        if (wv[first]) n_wr++; else n_rd++;
        snap[0][0] = exp_dout[0]; snap[0][1] = exp_dout[1];
        if (act[second]) begin
            exp_t[second] = exp_t[first] + 2 + lat(wv[second]);
            model_apply(second, wv[second], av[second], dv[second]);
            if (wv[second]) n_wr++; else n_rd++;
        end
        snap[1][0] = exp_dout[0]; snap[1][1] = exp_dout[1];
        oe_cnt = 0; we_cnt = 0; setup_cnt = 0;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_din = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_din = d1;
        for (int n = 0; n < 80 && !((done[0] || !act[0]) && (done[1] || !act[1])); n++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                ackb = (p == 0) ? m0_ack : m1_ack;
                if (ackb) begin
                    check_eq("ack_valid", {act[p], done[p]}, 2'b10);
                    got_t[p] = cyc;
                    done[p]  = 1;
                    o = (p == first) ? 0 : 1;
                    check_eq("dout0_at_ack", m0_dout, snap[o][0]);
                    check_eq("dout1_at_ack", m1_dout, snap[o][1]);
                    check_eq("recover_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
                    check_eq("recover_state", state, 3);
                end
            end
            @(posedge clk);
            #1;
            if (done[0]) m0_req = 1'b0;
            if (done[1]) m1_req = 1'b0;
        end
        if (act[0]) check_eq("ack_time_m0", got_t[0], exp_t[0]);
        if (act[1]) check_eq("ack_time_m1", got_t[1], exp_t[1]);
        m0_req = 1'b0;
        m1_req = 1'b0;
        check_eq("oe_cycles", oe_cnt, WAIT * n_rd);
        check_eq("we_cycles", we_cnt, WAIT * n_wr);
        check_eq("setup_cycles", setup_cnt, n_wr);
        @(negedge clk);
        check_eq("ack_single_pulse", {m1_ack, m0_ack}, 0);
        @(posedge clk);
        #1;
    endtask

    // m0 keeps req high across three reads at addresses 0, 1, 2.
    task automatic back_to_back();
        int k, got, prev, exp_t;
        k = cyc;
        prev = 0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = '0; m0_din = '0;
        for (int i = 0; i < 3; i++) begin
            model_apply(0, 1'b0, AW'(i), '0);
            exp_t = (i == 0) ? k + 1 + WAIT : prev + WAIT + 2;
            got = -1;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (m0_ack) begin
                    got = cyc;
                    break;
                end
            end
            check_eq("b2b_ack_time", got, exp_t);
            if (i > 0) check_eq("b2b_spacing", got - prev, WAIT + 2);
            check_eq("b2b_dout", m0_dout, exp_dout[0]);
            check_eq("b2b_ce_high", sram_ce_n, 1);
            prev = got;
            @(posedge clk);
            #1;
            if (i < 2) m0_addr = AW'(i + 1);
            else       m0_req  = 1'b0;
        end
        @(negedge clk);
        check_eq("b2b_ack_clear", m0_ack, 0);
        @(posedge clk);
        #1;
    endtask

    // Reset lands in the second WRITE cycle: access aborts without an ack.
    task automatic abort_write();
        logic [1:0] acc;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 20'hABCDE; m1_din = 48'h0102_0304_0506;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_pre_we_n", sram_we_n, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_state", state, 0);
        check_eq("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
        check_eq("abort_ack", {m1_ack, m0_ack}, 0);
        check_eq("abort_douts", {m0_dout, m1_dout}, 0);
        rst = 1'b0;
        m1_req = 1'b0;
        model_reset();
        acc = '0;
        repeat (8) begin
            @(negedge clk);
            acc = acc | {m1_ack, m0_ack};
        end
        check_eq("abort_no_ack", acc, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0]   rnd;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] rd0, rd1;
        int            mode;
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_din = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_din = '0;
        pad_mem[20'h00010] = 48'hABCDEF012345;
        exp_mem[20'h00010] = 48'hABCDEF012345;
        do_reset();

        run_pair(1, 0, 0, 0, 20'h00010, '0, '0, '0);
        check_eq("m0_read_value", m0_dout, 48'hABCDEF012345);
        check_eq("m1_dout_untouched", m1_dout, 0);

        run_pair(0, 1, 0, 1, '0, 20'hFFFFF, '0, 48'h123456789ABC);
        run_pair(1, 0, 0, 0, 20'hFFFFF, '0, '0, '0);
        check_eq("m0_readback", m0_dout, 48'h123456789ABC);

        do_reset();
        run_pair(1, 1, 0, 1, 20'h00010, 20'h00020, '0, 48'h0000_1111_2222);
        run_pair(1, 1, 0, 1, 20'h00020, 20'h00030, '0, 48'h3333_4444_5555);

        back_to_back();

        abort_write();
        run_pair(0, 1, 0, 0, '0, 20'hFFFFF, '0, '0);

        repeat (40) begin
            mode = $urandom_range(0, 2);
            rnd = {$urandom(), $urandom()}; rd0 = rnd[DW-1:0];
            rnd = {$urandom(), $urandom()}; rd1 = rnd[DW-1:0];
            ra0 = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : AW'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : AW'($urandom_range(0, 7));
            run_pair(mode != 1, mode != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     ra0, ra1, rd0, rd1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter CLK_FREQ, default 50, clock frequency in MHz.
REQ-002 Parameter T_ACCESS_NS, default 70, SRAM read/write cycle time in ns.
REQ-003 Parameter ADDR_BITS, default 20, SRAM word-address width.
REQ-004 Parameter DATA_BITS, default 48, SRAM data width.
REQ-005 clk  input  1  single clock; all logic on posedge clk.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 For each N in {0,1}: mN_req  input  1  access request, held high until mN_ack.
REQ-008 mN_we  input  1  1=write, 0=read; held stable while mN_req is high.
REQ-009 mN_addr  input  ADDR_BITS  word address; held stable while mN_req is high.
REQ-010 mN_din  input  DATA_BITS  write data; held stable while mN_req is high.
REQ-011 mN_dout  output  DATA_BITS  read data, registered.
REQ-012 mN_ack  output  1  one-cycle completion pulse.
REQ-013 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes, registered.
REQ-014 sram_addr  output  ADDR_BITS  SRAM address, registered.
REQ-015 sram_dout  output  DATA_BITS  write data to pad; sram_din  input  DATA_BITS  read data from pad.
REQ-016 state  output  2  current FSM state, for board LEDs.

Function
REQ-017 WAIT = ceil(T_ACCESS_NS*CLK_FREQ/1000), minimum 1, computed at elaboration (4 at defaults).
REQ-018 FSM states: IDLE(0), READ(1), WRITE(2), RECOVER(3); WRITE contains a one-cycle address-setup phase.
REQ-019 IDLE: all strobes high; on the first edge at which any mN_req is high, grant one port, register its addr and data, and leave IDLE.
REQ-020 Arbitration round-robin: with both requests high, grant the port not granted last; with one request high, grant that port.
REQ-021 Read: READ for WAIT cycles with ce_n=0, oe_n=0; sram_din captured into mN_dout at the final READ edge; then RECOVER.
REQ-022 Write: one setup cycle (ce_n=0, we_n=1, addr/data driven), then WAIT cycles with we_n=0, then RECOVER.
REQ-023 RECOVER (one cycle): ce_n, oe_n and we_n high; sram_addr and sram_dout held; granted mN_ack=1; next state IDLE.
REQ-024 Latency from the request-sampling edge to the ack cycle: read WAIT edges; write WAIT+1 edges.
REQ-025 Minimum request spacing: WAIT+2 cycles for a read, WAIT+3 for a write.
REQ-026 mN_dout holds its value until that port's next read completes; writes and the other port's traffic leave it unchanged.
REQ-027 Requests arriving outside IDLE wait; requests are never dropped or reordered within a port.
REQ-028 A requester that still holds req in the cycle after ack starts a new access, which gives the other port priority under contention.
REQ-029 Never assert oe_n=0 and we_n=0 together; never change sram_addr while we_n=0.

Reset
REQ-030 On rst: state IDLE; ce_n, oe_n and we_n =1; sram_addr=0; sram_dout=0; mN_dout=0; mN_ack=0; last-grant = port 1, so port 0 wins the first tie.
REQ-031 rst mid-access aborts the access at the next edge with strobes high and no ack issued.

Structure
REQ-032 The state encodings and the T_ACCESS_NS default live in the shared header; the WAIT ceiling uses the shared math function.
REQ-033 Single module; no sub-module (round-robin logic is a one-bit register).

Verification (CLK_FREQ=50, T_ACCESS_NS=70, WAIT=4)
REQ-034 m0 reads 0x00010 with model data 0xABCDEF012345 -> oe_n=0 for 4 cycles, m0_ack after 4 edges, m0_dout=0xABCDEF012345, m1_dout=0.
REQ-035 m1 writes 0x123456789ABC to 0xFFFFF -> one setup cycle, we_n=0 for 4 cycles with addr stable, ack after 5 edges; m0 readback returns the same value.
REQ-036 m0 and m1 request on the same edge after reset -> m0 served first, m1 on the next IDLE; both repeat -> grants alternate 0,1,0,1.
REQ-037 Assert rst during the 2nd WRITE cycle -> next edge strobes high, state=0, no ack; the following request completes normally.
REQ-038 m0 holds req for 3 back-to-back reads at 0,1,2 -> acks spaced 6 cycles apart, with ce_n high one cycle between accesses.
